// File: rtl/mips_fetch_if.sv
// mips_fetch_if: signal bundle between the fetch stage and its surroundings
// Signals:
//   imem_req_valid/imem_req_ready/imem_addr  word read request to instruction memory
//   imem_rsp_valid/imem_rsp_data              in-order read response
//   redir_valid/redir_pc                      redirect from branch/jump resolution
//   halt                                      stop fetching (sticky until reset)
//   if_valid/if_ready/if_inst/if_pc           head instruction handshake towards decode
//   dcd_op/dcd_funct2/dcd_rt                  pre-split fields of if_inst
//   fetch_fault/fetch_halted                  status
// Modports: master = fetch stage, slave = memory/decode/control side
interface mips_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        halt;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [5:0]  dcd_op;
   logic [5:0]  dcd_funct2;
   logic [4:0]  dcd_rt;
   logic        fetch_fault;
   logic        fetch_halted;
   modport master (
      output imem_req_valid, imem_addr, if_valid, if_inst, if_pc,
             dcd_op, dcd_funct2, dcd_rt, fetch_fault, fetch_halted,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redir_valid, redir_pc, halt, if_ready
   );
   modport slave (
      input  imem_req_valid, imem_addr, if_valid, if_inst, if_pc,
             dcd_op, dcd_funct2, dcd_rt, fetch_fault, fetch_halted,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redir_valid, redir_pc, halt, if_ready
   );
endinterface

// File: rtl/mips_fetch.sv
// mips_fetch: instruction fetch stage - PC, credit-limited imem reads, instruction FIFO to decode
// Ports:
//   clk    clock
//   rst_b  synchronous reset, active low
//   bus    mips_fetch_if.master: imem request/response, redirect/halt inputs,
//          head instruction with PC and pre-split decode fields, fault/halt status
module mips_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter int          IBUF_DEPTH = 4,
   parameter int          MAX_OUTST  = 2
) (
   input logic          clk,
   input logic          rst_b,
   mips_fetch_if.master bus
);
   localparam int AW = $clog2(IBUF_DEPTH);
   localparam int CW = $clog2(IBUF_DEPTH + 1);
   localparam logic [CW-1:0] MAX_O = CW'(MAX_OUTST);
   localparam logic [CW:0]   DEPTH = (CW+1)'(IBUF_DEPTH);
   typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
   state_t        state, state_nx;
   logic [31:0]   pc;
   logic [31:0]   inst_q [IBUF_DEPTH];
   logic [31:0]   pc_q   [IBUF_DEPTH];
   logic [31:0]   tag_q  [IBUF_DEPTH];
   logic [AW-1:0] wp, rp, tw, tr;
   logic [CW-1:0] count, outst, drop;
   logic [CW:0]   in_use;
   logic          acc, rsp, push, pop;
   // every word in flight has a reserved FIFO slot, so responses never overflow
   assign in_use = {1'b0, outst} + {1'b0, count};
   assign acc    = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp    = bus.imem_rsp_valid;
   // words requested before a redirect are counted in drop and never reach the FIFO
   assign push   = rsp && !bus.redir_valid && drop == '0 && state != FAULT;
   assign pop    = bus.if_valid && bus.if_ready && !bus.redir_valid;
   assign bus.imem_req_valid = rst_b && state == RUN && !bus.redir_valid &&
                               outst < MAX_O && in_use < DEPTH;
   assign bus.imem_addr    = pc;
   assign bus.if_valid     = count != '0;
   assign bus.if_inst      = bus.if_valid ? inst_q[rp] : '0;
   assign bus.if_pc        = bus.if_valid ? pc_q[rp] : '0;
   assign bus.dcd_op       = bus.if_inst[31:26];
   assign bus.dcd_funct2   = bus.if_inst[5:0];
   assign bus.dcd_rt       = bus.if_inst[20:16];
   assign bus.fetch_fault  = state == FAULT;
   assign bus.fetch_halted = state == HALT;
   // a misaligned redirect outranks a simultaneous halt
   always_comb begin
      state_nx = state;
      if (state == RUN)
         state_nx = (bus.redir_valid && bus.redir_pc[1:0] != 2'b00) ? FAULT :
                    bus.halt ? HALT : RUN;
   end
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state <= RUN;
         pc    <= RESET_PC;
         wp    <= '0;
         rp    <= '0;
         tw    <= '0;
         tr    <= '0;
         count <= '0;
         outst <= '0;
         drop  <= '0;
      end else begin
         state <= state_nx;
         outst <= outst + CW'(acc) - CW'(rsp);
         if (acc) begin
            pc <= pc + 32'd4;
            tw <= tw + AW'(1);
         end
         // the tag FIFO tracks every outstanding request, dropped or not
         if (rsp) tr <= tr + AW'(1);
         if (bus.redir_valid) begin
            pc    <= bus.redir_pc;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            drop  <= outst - CW'(rsp);
         end else begin
            if (rsp && drop != '0) drop <= drop - CW'(1);
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (acc) tag_q[tw] <= pc;
      if (push) begin
         inst_q[wp] <= bus.imem_rsp_data;
         pc_q[wp]   <= tag_q[tr];
      end
   end
endmodule
